// File: rtl/dmem_pkg.sv
// dmem_pkg: shared data width, default geometry/latency and FSM state encoding for the doubleword memory responder
package dmem_pkg;
  localparam int DW = 64;
  localparam int DMEM_DEPTH = 256;
  localparam int DMEM_LATENCY = 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: doubleword storage with one synchronous write port and one combinational read port, never cleared
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  // write port: contents survive reset by design
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding doubleword load/store responder with fixed wait latency; DMEM_RESPONDER_ERR_EN enables alignment/range errors
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [63:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_e, bad, enter_resp, mem_we, err_q, err_d;
  logic [63:0] addr_q, addr_e;
  logic [DW-1:0] wdata_q, wdata_e, rdata_q, rdata_d, mem_rdata;
  // while idle the live request is used so a zero-latency accept can commit on its own edge
  assign we_e = state_q == IDLE ? req_we : we_q;
  assign addr_e = state_q == IDLE ? req_addr : addr_q;
  assign wdata_e = state_q == IDLE ? req_wdata : wdata_q;
`ifdef DMEM_RESPONDER_ERR_EN
  assign bad = (|addr_e[2:0]) || (|addr_e[63:AW+3]);
`else
  logic unused_addr;
  assign bad = 1'b0;
  assign unused_addr = ^{addr_e[63:AW+3], addr_e[2:0]};
`endif
  assign mem_we = enter_resp && we_e && !bad && !reset;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err = err_q;
  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (addr_e[AW+2:3]),
    .wdata_i (wdata_e),
    .raddr_i (addr_e[AW+2:3]),
    .rdata_o (mem_rdata)
  );
  // next state, wait counting and response capture on the edge that enters RESP
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        enter_resp = LATENCY == 0;
        state_d = LATENCY == 0 ? RESP : WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        enter_resp = cnt_q == 4'(LATENCY - 1);
        state_d = enter_resp ? RESP : WAIT;
        cnt_d = cnt_q + 4'd1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    rdata_d = enter_resp ? ((we_e || bad) ? '0 : mem_rdata) : rdata_q;
    err_d = enter_resp ? bad : err_q;
  end
  // control and response registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  // request capture so later req_* changes cannot disturb an accepted transaction
  always_ff @(posedge clk)
    if (req_valid && req_ready) begin
      we_q <= req_we;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table-driven bench for a LATENCY=2 and a LATENCY=0 responder
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
  logic [63:0] z_req_addr = '0, z_req_wdata = '0;
  logic z_req_ready, z_rsp_valid, z_rsp_err;
  logic [63:0] z_rsp_rdata;
  int errors = 0, checks = 0;
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          hold;
    logic [63:0] rdata;
    logic        err;
  } vec_t;
  vec_t v [12];
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(256), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic txn(input vec_t t);
    int lat;
    logic [63:0] held;
    check("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_we = t.we; req_addr = t.addr; req_wdata = t.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~t.we; req_addr = ~t.addr; req_wdata = ~t.wdata;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      check("busy_ready", req_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, LAT + 1);
    check("rdata", rsp_rdata, t.rdata);
    check("err", rsp_err, t.err);
    held = rsp_rdata;
    repeat (t.hold) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, held);
      check("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("ret_valid", rsp_valid, 0);
    check("ret_ready", req_ready, 1);
  endtask
  task automatic txn0(input logic we, input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] exp);
    check("l0_idle_ready", z_req_ready, 1);
    z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_wdata = wdata;
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_addr = ~addr;
    check("l0_valid", z_rsp_valid, 1);
    check("l0_rdata", z_rsp_rdata, exp);
    check("l0_err", z_rsp_err, 0);
    z_rsp_ready = 1'b1;
    @(posedge clk); #1;
    z_rsp_ready = 1'b0;
    check("l0_ret_valid", z_rsp_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    v[0]  = '{1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 0, 64'h0, 1'b0};
    v[1]  = '{1'b0, 64'h10,  64'h0, 5, 64'hDEADBEEF_CAFEF00D, 1'b0};
    v[2]  = '{1'b1, 64'h18,  64'h11112222_33334444, 0, 64'h0, 1'b0};
    v[3]  = '{1'b1, 64'h0,   64'hA5A5A5A5_5A5A5A5A, 0, 64'h0, 1'b0};
    v[4]  = '{1'b1, 64'h7F8, 64'h01234567_89ABCDEF, 0, 64'h0, 1'b0};
    v[5]  = '{1'b0, 64'h7F8, 64'h0, 1, 64'h01234567_89ABCDEF, 1'b0};
    v[6]  = '{1'b1, 64'h08,  64'h0BBB0BBB_0BBB0BBB, 0, 64'h0, 1'b0};
`ifdef DMEM_RESPONDER_ERR_EN
    v[7]  = '{1'b1, 64'h0C,  64'h0CCC0CCC_0CCC0CCC, 0, 64'h0, 1'b1};
    v[8]  = '{1'b0, 64'h08,  64'h0, 0, 64'h0BBB0BBB_0BBB0BBB, 1'b0};
    v[9]  = '{1'b0, 64'h800, 64'h0, 2, 64'h0, 1'b1};
`else
    v[7]  = '{1'b1, 64'h0C,  64'h0CCC0CCC_0CCC0CCC, 0, 64'h0, 1'b0};
    v[8]  = '{1'b0, 64'h08,  64'h0, 0, 64'h0CCC0CCC_0CCC0CCC, 1'b0};
    v[9]  = '{1'b0, 64'h800, 64'h0, 2, 64'hA5A5A5A5_5A5A5A5A, 1'b0};
`endif
    v[10] = '{1'b0, 64'h0,   64'h0, 0, 64'hA5A5A5A5_5A5A5A5A, 1'b0};
    v[11] = '{1'b0, 64'h18,  64'h0, 0, 64'h11112222_33334444, 1'b0};
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_err", rsp_err, 0);
    check("rst_rdata", rsp_rdata, 0);
    for (int i = 0; i < 12; i++) txn(v[i]);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h18; req_wdata = 64'h99998888_77776666;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wait_ready", req_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("wrst_ready", req_ready, 1);
    check("wrst_rdata", rsp_rdata, 0);
    check("wrst_err", rsp_err, 0);
    for (int i = 0; i < 4; i++) begin
      check("wrst_no_rsp", rsp_valid, 0);
      @(posedge clk); #1;
    end
    txn('{1'b0, 64'h18, 64'h0, 0, 64'h11112222_33334444, 1'b0});
    txn0(1'b1, 64'h0, 64'h5555AAAA_CCCC3333, 64'h0);
    txn0(1'b0, 64'h0, 64'h0, 64'h5555AAAA_CCCC3333);
    txn0(1'b1, 64'h20, 64'h00000000_00000042, 64'h0);
    txn0(1'b0, 64'h20, 64'h0, 64'h00000000_00000042);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
